// File: rtl/bus_pkg.sv
// Shared system bus constants: control word layout, burst codes, arbiter state encoding.
package bus_pkg;

    localparam int unsigned BUS_WIDTH_DEF  = 32;
    localparam int unsigned CTRL_WIDTH_DEF = 8;

    localparam int unsigned CTRL_WAIT_BIT  = 0;
    localparam int unsigned CTRL_WE_BIT    = 1;
    localparam int unsigned CTRL_BURST_LSB = 2;
    localparam int unsigned CTRL_BURST_MSB = 4;

    localparam logic [2:0] BURST_1 = 3'b000;

    // Field view of the default-width control word, LSB last.
    typedef struct packed {
        logic [2:0] rsvd;
        logic [2:0] burst;
        logic       we;
        logic       wait_st;
    } ctrl_word_t;

    localparam int unsigned ST_WIDTH = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OWN     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side arbitration bundle: requests/grants plus the muxed shared bus.
interface bus_arbiter_if import bus_pkg::*; #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_WIDTH   = 2,
    parameter int unsigned BUS_WIDTH   = BUS_WIDTH_DEF,
    parameter int unsigned CTRL_WIDTH  = CTRL_WIDTH_DEF
);
    logic [NUM_MASTERS-1:0]            req;
    logic [NUM_MASTERS-1:0]            ack;
    logic [NUM_MASTERS*BUS_WIDTH-1:0]  m_bus;
    logic [NUM_MASTERS*CTRL_WIDTH-1:0] m_ctrl;
    logic [BUS_WIDTH-1:0]              bus_out;
    logic [CTRL_WIDTH-1:0]             ctrl_out;
    logic [IDX_WIDTH-1:0]              owner;
    logic                              busy;
    logic                              timeout_err;

    // The arbiter drives the shared bus.
    modport master (
        input  req, m_bus, m_ctrl,
        output ack, bus_out, ctrl_out, owner, busy, timeout_err
    );

    modport slave (
        output req, m_bus, m_ctrl,
        input  ack, bus_out, ctrl_out, owner, busy, timeout_err
    );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin pick: rotate req so last+1 sits at bit 0, find first set, rotate index back.
module rr_pick #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_WIDTH   = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_WIDTH-1:0]   last,
    output logic [IDX_WIDTH-1:0]   grant_idx,
    output logic                   valid
);
    localparam int unsigned SUM_WIDTH = IDX_WIDTH + 1;

    logic [SUM_WIDTH-1:0]   start;
    logic [SUM_WIDTH-1:0]   sum;
    logic [NUM_MASTERS-1:0] rot;
    logic [IDX_WIDTH-1:0]   ffs;

    assign start = SUM_WIDTH'(last) + SUM_WIDTH'(1);
    assign rot   = NUM_MASTERS'({req, req} >> start);

    // Lowest set bit wins; scanning downward leaves the lowest one last.
    always_comb begin
        valid = 1'b0;
        ffs   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid = 1'b1;
                ffs   = IDX_WIDTH'(i);
            end
        end
    end

    assign sum       = SUM_WIDTH'(ffs) + start;
    assign grant_idx = (sum >= SUM_WIDTH'(NUM_MASTERS))
                     ? IDX_WIDTH'(sum - SUM_WIDTH'(NUM_MASTERS))
                     : IDX_WIDTH'(sum);
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with tenure timeout and owner-steered output mux.
module bus_arbiter import bus_pkg::*; #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_WIDTH   = 2,
    parameter int unsigned BUS_WIDTH   = BUS_WIDTH_DEF,
    parameter int unsigned CTRL_WIDTH  = CTRL_WIDTH_DEF,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned TMO_WIDTH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);
    logic [ST_WIDTH-1:0]  state_q, state_d;
    logic [IDX_WIDTH-1:0] owner_q, owner_d;
    logic [IDX_WIDTH-1:0] last_q, last_d;
    logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
    logic                 tmo_err_q, tmo_err_d;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 pick_valid;
    logic                 own;

    logic [BUS_WIDTH-1:0]  m_bus_arr  [NUM_MASTERS];
    logic [CTRL_WIDTH-1:0] m_ctrl_arr [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unflatten
        assign m_bus_arr[i]  = bus.m_bus[i*BUS_WIDTH +: BUS_WIDTH];
        assign m_ctrl_arr[i] = bus.m_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
    end

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_pick (
        .req       (bus.req),
        .last      (last_q),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            last_q    <= IDX_WIDTH'(NUM_MASTERS - 1);
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        tmo_d     = tmo_q;
        tmo_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    tmo_d   = '0;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                tmo_d = tmo_q + TMO_WIDTH'(1);
                // A voluntary drop on the limit cycle counts as a normal release.
                if (!bus.req[owner_q]) begin
                    state_d = ST_RELEASE;
                end else if (tmo_q == TMO_WIDTH'(TIMEOUT - 1)) begin
                    state_d   = ST_RELEASE;
                    tmo_err_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus is quiet (WE=0, burst=000) whenever nobody owns it.
    assign own             = (state_q == ST_OWN);
    assign bus.ack         = own ? (NUM_MASTERS'(1) << owner_q) : '0;
    assign bus.busy        = own;
    assign bus.bus_out     = own ? m_bus_arr[owner_q]  : '0;
    assign bus.ctrl_out    = own ? m_ctrl_arr[owner_q] : '0;
    assign bus.owner       = owner_q;
    assign bus.timeout_err = tmo_err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant latency, rotation, priority, timeout, reset.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int unsigned NM  = 4;
    localparam int unsigned IW  = 2;
    localparam int unsigned BW  = 32;
    localparam int unsigned CW  = 8;
    localparam int unsigned TMO = 255;
    localparam int unsigned TW  = 8;

    localparam logic [BW-1:0] MB0 = 32'hA0A0_0000;
    localparam logic [BW-1:0] MB1 = 32'hB1B1_1111;
    localparam logic [BW-1:0] MB2 = 32'hC2C2_2222;
    localparam logic [BW-1:0] MB3 = 32'hD3D3_3333;
    localparam logic [CW-1:0] MC0 = 8'h06;
    localparam logic [CW-1:0] MC1 = 8'h02;
    localparam logic [CW-1:0] MC2 = 8'h05;
    localparam logic [CW-1:0] MC3 = 8'h0E;

    logic clk = 1'b0;
    logic rst;

    bus_arbiter_if #(.NUM_MASTERS(NM), .IDX_WIDTH(IW), .BUS_WIDTH(BW), .CTRL_WIDTH(CW)) bif ();

    bus_arbiter #(
        .NUM_MASTERS (NM),
        .IDX_WIDTH   (IW),
        .BUS_WIDTH   (BW),
        .CTRL_WIDTH  (CW),
        .TIMEOUT     (TMO),
        .TMO_WIDTH   (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int          cnt;
        int          early;
        bit          done;
        logic [NM-1:0] mask;

        cnt   = 0;
        early = 0;
        done  = 1'b0;
        rst        = 1'b1;
        bif.req    = '0;
        bif.m_bus  = {MB3, MB2, MB1, MB0};
        bif.m_ctrl = {MC3, MC2, MC1, MC0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack",   64'(bif.ack),         64'(0));
        check("rst_busy",  64'(bif.busy),        64'(0));
        check("rst_owner", 64'(bif.owner),       64'(0));
        check("rst_bus",   64'(bif.bus_out),     64'(0));
        check("rst_ctrl",  64'(bif.ctrl_out),    64'(0));
        check("rst_tmo",   64'(bif.timeout_err), 64'(0));
        rst = 1'b0;

        // Single master grant / release
        @(negedge clk);
        bif.req = 4'b0001;
        check("t1_no_comb_path", 64'(bif.ack), 64'(0));
        @(negedge clk);
        check("t1_ack",   64'(bif.ack),      64'(4'b0001));
        check("t1_busy",  64'(bif.busy),     64'(1));
        check("t1_owner", 64'(bif.owner),    64'(0));
        check("t1_bus",   64'(bif.bus_out),  64'(MB0));
        check("t1_ctrl",  64'(bif.ctrl_out), 64'(MC0));
        bif.req = 4'b0000;
        @(negedge clk);
        check("t1_rel_ack",  64'(bif.ack),      64'(0));
        check("t1_rel_busy", 64'(bif.busy),     64'(0));
        check("t1_rel_bus",  64'(bif.bus_out),  64'(0));
        check("t1_rel_ctrl", 64'(bif.ctrl_out), 64'(0));
        @(negedge clk);
        check("t1_idle_ack", 64'(bif.ack), 64'(0));

        // Re-reset so master 0 leads the rotation
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // All four requesting: 0,1,2,3,0 with 3-cycle tenures
        bif.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            mask = NM'(1) << (g % 4);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("t2_ack",   64'(bif.ack),   64'(mask));
                check("t2_owner", 64'(bif.owner), 64'(g % 4));
                if (c == 2) bif.req = bif.req & ~mask;
            end
            @(negedge clk);
            check("t2_rel_ack",  64'(bif.ack),  64'(0));
            check("t2_rel_busy", 64'(bif.busy), 64'(0));
            bif.req = (g == 4) ? 4'b0000 : (bif.req | mask);
            @(negedge clk);
            check("t2_idle_ack", 64'(bif.ack), 64'(0));
        end

        // Master 1 write, sets last=1
        bif.req = 4'b0010;
        @(negedge clk);
        check("t3_m1_ack",  64'(bif.ack),      64'(4'b0010));
        check("t3_m1_ctrl", 64'(bif.ctrl_out), 64'(8'h02));
        check("t3_m1_bus",  64'(bif.bus_out),  64'(MB1));
        bif.req = 4'b0000;
        @(negedge clk);
        check("t3_rel_ctrl", 64'(bif.ctrl_out), 64'(0));
        @(negedge clk);
        check("t3_idle_ctrl", 64'(bif.ctrl_out), 64'(0));
        check("t3_idle_bus",  64'(bif.bus_out),  64'(0));

        // last=1, req=0101: master 2 first, master 0 waits
        bif.req = 4'b0101;
        @(negedge clk);
        check("t3_pick2",  64'(bif.ack),   64'(4'b0100));
        check("t3_owner2", 64'(bif.owner), 64'(2));
        @(negedge clk);
        check("t3_no_preempt", 64'(bif.ack), 64'(4'b0100));
        bif.req = 4'b0001;
        @(negedge clk);
        check("t3_rel_ack", 64'(bif.ack), 64'(0));
        @(negedge clk);
        check("t3_idle_ack", 64'(bif.ack), 64'(0));
        @(negedge clk);
        check("t3_pick0", 64'(bif.ack), 64'(4'b0001));
        bif.req = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        // Master 3 hangs: forced release after TIMEOUT cycles
        bif.req = 4'b1000;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (bif.ack == 4'b1000) begin
                cnt++;
                if (bif.timeout_err) early++;
            end else if (cnt > 0) begin
                done = 1'b1;
            end
        end
        check("t4_tenure",     64'(cnt),             64'(TMO));
        check("t4_early_tmo",  64'(early),           64'(0));
        check("t4_tmo_pulse",  64'(bif.timeout_err), 64'(1));
        check("t4_rel_ack",    64'(bif.ack),         64'(0));
        @(negedge clk);
        check("t4_pulse_end",  64'(bif.timeout_err), 64'(0));
        check("t4_idle_ack",   64'(bif.ack),         64'(0));
        @(negedge clk);
        check("t4_regrant",    64'(bif.ack),         64'(4'b1000));
        // Drop exactly on the limit cycle: normal release
        repeat (TMO - 1) @(negedge clk);
        check("t4_last_cycle", 64'(bif.ack), 64'(4'b1000));
        bif.req = 4'b0000;
        @(negedge clk);
        check("t4_limit_rel_ack", 64'(bif.ack),         64'(0));
        check("t4_limit_no_tmo",  64'(bif.timeout_err), 64'(0));
        @(negedge clk);
        check("t4_limit_idle_tmo", 64'(bif.timeout_err), 64'(0));

        // Reset mid-OWN drops everything immediately
        bif.req = 4'b0010;
        @(negedge clk);
        check("t5_ack",  64'(bif.ack),      64'(4'b0010));
        check("t5_ctrl", 64'(bif.ctrl_out), 64'(8'h02));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_ack",   64'(bif.ack),      64'(0));
        check("t5_rst_busy",  64'(bif.busy),     64'(0));
        check("t5_rst_bus",   64'(bif.bus_out),  64'(0));
        check("t5_rst_ctrl",  64'(bif.ctrl_out), 64'(0));
        check("t5_rst_owner", 64'(bif.owner),    64'(0));
        @(negedge clk);
        rst     = 1'b0;
        bif.req = 4'b0000;
        @(negedge clk);
        check("t5_post_ack", 64'(bif.ack), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
